mem_arbiter: RTL

Two-port arbiter that shares the single-ported `Memory` between the `ControlUnit`-driven CPU datapath (port 0) and a DMA/loader requester (port 1). It serialises requests into fixed-latency memory transactions and drives the memory address, data and strobe lines. Grants are round-robin, with an optional bounded lock for back-to-back bursts. The CPU stalls on its request until `Done[0]`.

---
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-ported memory.
// Port 0 is the CPU datapath, port 1 the DMA/loader. Each granted request
// becomes a fixed three-cycle transaction IDLE -> ACCESS -> RESP. A port that
// holds Lock keeps ownership for up to MAX_HOLD consecutive transactions while
// the other port is waiting.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   Req/Lock/We [1:0]   per-port request, burst lock, write enable
//   Addr0/1, Wdata0/1   per-port address and write data
//   Gnt, Done [1:0]     registered one-hot grant, one-cycle completion pulse
//   Rdata               shared read data, valid with Done on reads
//   Busy                transaction in flight
//   MemAddr/MemWdata    latched address/data to memory
//   MemRead/MemWrite    memory strobes, high only in ACCESS
//   MemRdata            memory read data, valid the cycle after MemRead
module mem_arbiter #(
    parameter int unsigned WORD_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned MAX_HOLD      = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [1:0]               Req,
    input  logic [1:0]               Lock,
    input  logic [1:0]               We,
    input  logic [ADDRESS_WIDTH-1:0] Addr0,
    input  logic [ADDRESS_WIDTH-1:0] Addr1,
    input  logic [WORD_WIDTH-1:0]    Wdata0,
    input  logic [WORD_WIDTH-1:0]    Wdata1,
    output logic [1:0]               Gnt,
    output logic [1:0]               Done,
    output logic [WORD_WIDTH-1:0]    Rdata,
    output logic                     Busy,
    output logic [ADDRESS_WIDTH-1:0] MemAddr,
    output logic [WORD_WIDTH-1:0]    MemWdata,
    output logic                     MemRead,
    output logic                     MemWrite,
    input  logic [WORD_WIDTH-1:0]    MemRdata
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               gnt_q, gnt_d;
    logic [1:0]               done_q, done_d;
    logic [WORD_WIDTH-1:0]    rdata_q, rdata_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     we_q, we_d;
    logic                     lock_q, lock_d;
    logic                     win_q, win_d;
    logic                     last_q, last_d;
    logic                     owner_vld_q, owner_vld_d;
    logic                     owner_q, owner_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic                     pick;
    logic                     owner_keep;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            lock_q      <= 1'b0;
            win_q       <= 1'b0;
            last_q      <= 1'b1;
            owner_vld_q <= 1'b0;
            owner_q     <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            lock_q      <= lock_d;
            win_q       <= win_d;
            last_q      <= last_d;
            owner_vld_q <= owner_vld_d;
            owner_q     <= owner_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        lock_d      = lock_q;
        win_d       = win_q;
        last_d      = last_q;
        owner_vld_d = owner_vld_q;
        owner_d     = owner_q;
        hold_d      = hold_q;
        pick        = 1'b0;
        owner_keep  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Owner keeps the memory while it requests, unless it has used
                // its full hold budget and the other port is waiting.
                owner_keep = owner_vld_q && Req[owner_q]
                             && ((hold_q < HOLD_MAX) || !Req[~owner_q]);
                if (owner_vld_q && !owner_keep) begin
                    owner_vld_d = 1'b0;
                    hold_d      = '0;
                end

                if (owner_keep) begin
                    pick = owner_q;
                end else if (Req == 2'b01) begin
                    pick = 1'b0;
                end else if (Req == 2'b10) begin
                    pick = 1'b1;
                end else begin
                    pick = ~last_q;
                end

                if (Req != 2'b00) begin
                    state_d = ST_ACCESS;
                    win_d   = pick;
                    last_d  = pick;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    we_d    = We[pick];
                    lock_d  = Lock[pick];
                    addr_d  = pick ? Addr1 : Addr0;
                    wdata_d = pick ? Wdata1 : Wdata0;
                end
            end

            ST_ACCESS: begin
                state_d = ST_RESP;
                done_d  = win_q ? 2'b10 : 2'b01;
            end

            ST_RESP: begin
                if (!we_q) begin
                    rdata_d = MemRdata;
                end
                if (lock_q) begin
                    owner_vld_d = 1'b1;
                    owner_d     = win_q;
                    hold_d      = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
                end else begin
                    owner_vld_d = 1'b0;
                    hold_d      = '0;
                end
                gnt_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Gnt      = gnt_q;
    assign Done     = done_q;
    assign Busy     = (state_q != ST_IDLE);
    assign MemAddr  = addr_q;
    assign MemWdata = wdata_q;
    assign MemRead  = (state_q == ST_ACCESS) && !we_q;
    assign MemWrite = (state_q == ST_ACCESS) && we_q;

    // Memory data only arrives in RESP, the same cycle Done is high, so a read
    // passes MemRdata straight through in RESP; rdata_q holds it afterwards.
    assign Rdata = (state_q == ST_RESP && !we_q) ? MemRdata : rdata_q;

endmodule
